// File: rtl/uart_rx_char.sv
// UART receiver: 8N1 deframing (8E1 when UART_RX_PARITY_EN is defined), presents each good byte
// on curr_char for HOLD_CYCLES clocks and then clears it to 8'h00.
//
// state     | meaning
// IDLE      | line idle, waiting for a synchronized low (start edge)
// START     | mid-start-bit check after 8 ticks, filters glitches
// DATA      | sampling 8 data bits, LSB first, one per 16 ticks
// PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit, accept or reject the byte
// WAIT_HIGH | bad frame seen, waiting for the line to return high
module uart_rx_char #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BAUD        = 9_600,
  parameter int HOLD_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] curr_char,
  output logic       char_valid,
  output logic       frame_err
);

  localparam int DIV    = CLK_HZ / (BAUD * 16);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  logic [2:0]        state;
  logic              rx_meta;
  logic              rx_sync;
  logic [DIV_W-1:0]  clk_cnt;
  logic [3:0]        tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [HOLD_W-1:0] hold_cnt;
  logic              tick;
  logic              sample;
  logic              start_det;
  logic              stop_sample;
  logic              accept;
  logic              reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign start_det = (state == S_IDLE) && !rx_sync;
  assign tick      = (clk_cnt == '0);
  assign sample    = tick && (tick_cnt == 4'd0);

  // Down-counter reloaded on the start edge so every sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (rst)
      clk_cnt <= '0;
    else if (start_det || tick)
      clk_cnt <= DIV_W'(DIV - 1);
    else
      clk_cnt <= clk_cnt - DIV_W'(1);
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  always_ff @(posedge clk) begin
    if (rst)
      par_bad <= 1'b0;
    else if ((state == S_PARITY) && sample)
      par_bad <= (^shift) ^ rx_sync;
  end
`else
  logic par_bad;
  assign par_bad = 1'b0;
`endif

  assign stop_sample = (state == S_STOP) && sample;
  assign accept      = stop_sample && rx_sync && !par_bad;
  assign reject      = stop_sample && !(rx_sync && !par_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
    end else begin
      if (tick && state != S_IDLE)
        tick_cnt <= (tick_cnt == 4'd0) ? 4'd15 : tick_cnt - 4'd1;
      case (state)
        S_IDLE: begin
          if (!rx_sync) begin
            state    <= S_START;
            tick_cnt <= 4'd7;
          end
        end
        S_START: begin
          if (sample) begin
            if (rx_sync) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
        end
        S_DATA: begin
          if (sample) begin
            shift   <= {rx_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (sample)
            state <= S_STOP;
        end
`endif
        S_STOP: begin
          if (sample)
            state <= accept ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (rx_sync)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A new byte reloads the hold timer, so it takes priority over expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      curr_char  <= 8'h00;
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      char_valid <= accept;
      frame_err  <= reject;
      if (accept) begin
        curr_char <= shift;
        hold_cnt  <= HOLD_W'(HOLD_CYCLES);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
        if (hold_cnt == HOLD_W'(1))
          curr_char <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_char.sv
// Self-checking bench for uart_rx_char: event-queue model of accepted bytes and frame errors,
// compared every cycle, plus literal checks on latency, hold length and frame spacing.
module tb_uart_rx_char;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 10_000;
  localparam int HOLD   = 500;
  localparam int DIV    = CLK_HZ / (BAUD * 16);
  localparam int BIT    = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int FBITS   = 11;
  localparam int LAT_LIT = 1683;
  localparam int GAP_LIT = 1760;
`else
  localparam int FBITS   = 10;
  localparam int LAT_LIT = 1523;
  localparam int GAP_LIT = 1600;
`endif
  // Start edge to char_valid: 2 sync stages, 1 detect, half a bit, then the remaining full bits.
  localparam int LAT = 3 + (8 + 16 * (FBITS - 1)) * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] curr_char;
  logic       char_valid;
  logic       frame_err;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rst_q = 1'b1;

  int         acc_cyc[$];
  logic [7:0] acc_byte[$];
  int         err_cyc[$];

  int n_valid = 0, n_err = 0, last_valid = 0, prev_valid = 0, last_nz = 0;

  uart_rx_char #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .curr_char(curr_char), .char_valid(char_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin : compare
    logic [7:0] m_byte;
    int         hold_end;
    logic       exp_v, exp_e;
    m_byte   = 8'h00;
    hold_end = 0;
    forever begin
      @(negedge clk);
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (rst_q) begin
        m_byte   = 8'h00;
        hold_end = 0;
      end else begin
        while (acc_cyc.size() > 0 && acc_cyc[0] < cyc) begin
          void'(acc_cyc.pop_front());
          void'(acc_byte.pop_front());
        end
        while (err_cyc.size() > 0 && err_cyc[0] < cyc) void'(err_cyc.pop_front());
        if (acc_cyc.size() > 0 && acc_cyc[0] == cyc) begin
          void'(acc_cyc.pop_front());
          m_byte   = acc_byte.pop_front();
          hold_end = cyc + HOLD;
          exp_v    = 1'b1;
        end
        if (err_cyc.size() > 0 && err_cyc[0] == cyc) begin
          void'(err_cyc.pop_front());
          exp_e = 1'b1;
        end
      end
      if (cyc >= 1) begin
        check("char_valid", char_valid, exp_v);
        check("frame_err", frame_err, exp_e);
        check("curr_char", curr_char, (cyc < hold_end) ? m_byte : 8'h00);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (char_valid === 1'b1) begin
        n_valid++;
        prev_valid = last_valid;
        last_valid = cyc;
      end
      if (frame_err === 1'b1) n_err++;
      if (curr_char !== 8'h00) last_nz = cyc;
    end
  end

  initial begin : watchdog
    #(10 * 90_000);
    $display("FAIL watchdog: run exceeded time limit, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(logic v);
    rx = v;
    step(BIT);
  endtask

  task automatic send_frame(logic [7:0] b, logic par_ok, logic stop_v, int extra_low);
    if (par_ok && stop_v) begin
      acc_cyc.push_back(cyc + LAT);
      acc_byte.push_back(b);
    end else begin
      err_cyc.push_back(cyc + LAT);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_ok ? ^b : ~^b);
`endif
    drive_bit(stop_v);
    if (extra_low > 0) begin
      rx = 1'b0;
      step(extra_low);
    end
  endtask

  initial begin : driver
    int s, nv, ne;
    step(5);
    rst = 1'b0;
    step(20);
    check("reset curr_char", curr_char, 8'h00);

    // 1: single byte, latency and hold length
    s  = cyc;
    nv = n_valid;
    send_frame(8'h4C, 1'b1, 1'b1, 0);
    check("t1 latency", last_valid - s, LAT_LIT);
    check("t1 char", curr_char, 8'h4C);
    step(600);
    check("t1 hold length", last_nz - last_valid + 1, 500);
    check("t1 pulses", n_valid - nv, 1);
    check("t1 cleared", curr_char, 8'h00);

    // 2: back-to-back frames
    send_frame(8'h52, 1'b1, 1'b1, 0);
    send_frame(8'h4C, 1'b1, 1'b1, 0);
    check("t2 spacing", last_valid - prev_valid, GAP_LIT);
    check("t2 char", curr_char, 8'h4C);
    step(600);

    // 3: start glitch then a good frame
    nv = n_valid;
    ne = n_err;
    rx = 1'b0;
    step(40);
    rx = 1'b1;
    step(300);
    check("t3 glitch valid", n_valid - nv, 0);
    check("t3 glitch err", n_err - ne, 0);
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    check("t3 char", curr_char, 8'hA5);
    step(600);

    // 4: bad stop bit, line held low
    ne = n_err;
    nv = n_valid;
    send_frame(8'h4C, 1'b1, 1'b0, 2000 - BIT);
    check("t4 err pulses", n_err - ne, 1);
    check("t4 no valid", n_valid - nv, 0);
    rx = 1'b1;
    step(200);
    send_frame(8'h52, 1'b1, 1'b1, 0);
    check("t4 recover char", curr_char, 8'h52);
    step(600);

    // 5: reset in the middle of a frame's data bits
    send_frame(8'h52, 1'b1, 1'b1, 0);
    nv = n_valid;
    ne = n_err;
    drive_bit(1'b0);
    drive_bit(1'b0);
    check("t5 pre-rst char", curr_char, 8'h52);
    rst = 1'b1;
    rx  = 1'b1;
    step(1);
    check("t5 rst char", curr_char, 8'h00);
    step(3);
    rst = 1'b0;
    step(100);
    check("t5 no pulses", (n_valid - nv) + (n_err - ne), 0);
    send_frame(8'h52, 1'b1, 1'b1, 0);
    check("t5 fresh char", curr_char, 8'h52);
    step(600);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then parity bad
    send_frame(8'h4C, 1'b1, 1'b1, 0);
    check("t6 good parity", curr_char, 8'h4C);
    step(600);
    ne = n_err;
    send_frame(8'h4C, 1'b0, 1'b1, 0);
    check("t6 parity err", n_err - ne, 1);
    check("t6 char", curr_char, 8'h00);
    step(300);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
